scroll_msg_sched: RTL and testbench
===================================

# scroll_msg_sched

Scheduler for the 40-bit scrolling instruction window shown on the ATM display. Up to four ATM-FSM sources request messages: error, enter PIN, enter amount, and take cash. The block arbitrates among pending requests and sequences one message at a time into the shared window, one 5-bit character per clock. Each message then scrolls off with blanks, and the block pulses `done`. It replaces per-message free-running text generators with one sequenced datapath.

## Interface
- `NUM_MSG`, 4: number of message sources/IDs.
- `CHAR_W`, 5: character code width.
- `WIN_CHARS`, 8: characters visible in `window`; `window` width = `CHAR_W*WIN_CHARS`.
- `MAX_LEN`, 16: maximum message length; index width = 4.

Ports:
- `sec_clock`  in  1  display-rate clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_MSG  request pulses; bit i requests message i; any width ≥1 cycle.
- `window`  out  40  display characters; oldest char in [39:35], newest in [4:0].
- `busy`  out  1  high while a message is sequencing.
- `active_id`  out  2  ID currently being sequenced; holds last ID when idle.
- `done`  out  1  one-cycle pulse when a message fully scrolls off.
- `abort`  out  1  one-cycle pulse when a message is preempted; constant 0 without the macro.

## Operation
- Character code: 0 = blank, 1..26 = A..Z.
- Message ROM:
  - id0 "ERROR", length 5.
  - id1 "ENTER PIN", length 9.
  - id2 "ENTER AMOUNT", length 12.
  - id3 "TAKE CASH", length 9.
- Pending register: `pending <= (pending & ~gnt_mask) | req` every edge.
  - A request for the ID being granted on the same edge stays pending and replays afterwards.
  - Repeated requests while a bit is already pending merge into one.
- Arbitration: fixed priority, lowest index wins. It is evaluated only in IDLE (and in SHIFT/TAIL when preemption is enabled).
- FSM states:
  - IDLE: if `pending != 0`, grant the highest-priority ID, then `active_id <= id`, `window <= 0`, `idx <= 0`, `busy <= 1`, go to SHIFT.
  - SHIFT: `window <= {window[34:0], char(active_id, idx)}`, `idx++`. On `idx == len-1`, go to TAIL with `tcnt <= 0`.
  - TAIL: shift in blank each edge, `tcnt++`. On the WIN_CHARS-th blank: `done <= 1`, `busy <= 0`, go to IDLE. `window` is now all zero.
- `done` and `abort` are high for exactly one cycle after the edge that sets them.
- Reset mid-operation clears the state, pending, window and all outputs; no `done` is produced.

## Timing
- Reset values:
  - `window` = 0, `busy` = 0, `active_id` = 0, `done` = 0, `abort` = 0.
  - `pending` = 0, state = IDLE.
- `req` high at edge k → pending at k, grant (`busy` = 1, window cleared) at k+1, first character in `window[4:0]` at k+2.
- A message of length L is busy for 1 + L + WIN_CHARS edges; `done` is asserted on the last of them.
- Back-to-back: if `pending != 0` when `done` is set, the next grant occurs on the following edge. There is one IDLE cycle between messages.

## Configuration
- `SCROLL_PREEMPT_EN` defined:
  - In SHIFT or TAIL, a pending ID with index < `active_id` aborts the current message on that edge.
  - On that edge: `abort <= 1`, no `done`, `window <= 0`, the new ID is granted, and the pending bit of the aborted ID is not restored.
  - The new message's first character appears one edge later.
- Undefined: messages always run to completion. `abort` is tied to 0 and arbitration occurs only in IDLE.

## Structure
- Package `scroll_pkg` contains:
  - `CHAR_W` and `WIN_CHARS`.
  - Character constants `CH_BLANK` and `CH_A`..`CH_Z`.
  - Message ID constants `MSG_ERROR`, `MSG_PIN`, `MSG_AMOUNT`, `MSG_CASH`.
  - The FSM state enum {IDLE, SHIFT, TAIL}.
- Sub-module `scroll_msg_rom` is combinational: inputs `id` and `idx`, outputs `char` and `len`. An `idx` beyond the message length returns blank.

## Test plan
- Reset, then req[2] for one cycle:
  - At grant+12, `window` = {18,0,1,13,15,21,14,20} ("R AMOUNT").
  - `done` pulses at grant+20, then `window` = 0 and `busy` = 0.
- req[3] and req[1] asserted on the same edge → "ENTER PIN" is sequenced first. "TAKE CASH" is granted on the edge after `done`, with one idle cycle between.
- req[1] asserted again during its own scroll → exactly one replay of id1 follows. A req held for 5 cycles while id1 is pending still yields a single replay.
- `rst` asserted at grant+4 of id2 → next edge all outputs and `pending` are 0. No `done` is produced and no replay occurs.
- With `SCROLL_PREEMPT_EN`: req[0] at grant+6 of id2 → `abort` pulses, the window clears, and "ERROR" follows. `done` fires once, for id0 only, and id2 does not replay.
- Without the macro, the same stimulus → id2 completes with `done`, then id0 is granted; `abort` stays 0.

Source files
------------

// File: rtl/scroll_pkg.sv
// scroll_pkg
// Shared constants for the ATM scrolling-message scheduler: display geometry,
// 5-bit character codes (0 = blank, 1..26 = A..Z), message IDs and FSM states.
package scroll_pkg;

    localparam int NUM_MSG   = 4;
    localparam int CHAR_W    = 5;
    localparam int WIN_CHARS = 8;
    localparam int MAX_LEN   = 16;
    localparam int IDX_W     = 4;
    localparam int ID_W      = 2;

    localparam logic [CHAR_W-1:0] CH_BLANK = 5'd0;
    localparam logic [CHAR_W-1:0] CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
    localparam logic [CHAR_W-1:0] CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
    localparam logic [CHAR_W-1:0] CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
    localparam logic [CHAR_W-1:0] CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
    localparam logic [CHAR_W-1:0] CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
    localparam logic [CHAR_W-1:0] CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
    localparam logic [CHAR_W-1:0] CH_Y = 5'd25, CH_Z = 5'd26;

    localparam logic [ID_W-1:0] MSG_ERROR  = 2'd0;
    localparam logic [ID_W-1:0] MSG_PIN    = 2'd1;
    localparam logic [ID_W-1:0] MSG_AMOUNT = 2'd2;
    localparam logic [ID_W-1:0] MSG_CASH   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

endpackage

// File: rtl/scroll_msg_rom.sv
// scroll_msg_rom
// Combinational message ROM. Returns the character at position idx of message
// id and that message's length; positions past the end read as blank.
// Ports:
//   id   in   message ID
//   idx  in   character position within the message
//   char out  character code at that position
//   len  out  message length in characters
module scroll_msg_rom
    import scroll_pkg::*;
(
    input  logic [ID_W-1:0]   id,
    input  logic [IDX_W-1:0]  idx,
    output logic [CHAR_W-1:0] char,
    output logic [IDX_W-1:0]  len
);

    always_comb begin
        char = CH_BLANK;
        len  = 4'd0;
        case (id)
            MSG_ERROR: begin
                len = 4'd5;
                case (idx)
                    4'd0: char = CH_E;  4'd1: char = CH_R;  4'd2: char = CH_R;
                    4'd3: char = CH_O;  4'd4: char = CH_R;
                    default: char = CH_BLANK;
                endcase
            end
            MSG_PIN: begin
                len = 4'd9;
                case (idx)
                    4'd0: char = CH_E;  4'd1: char = CH_N;  4'd2: char = CH_T;
                    4'd3: char = CH_E;  4'd4: char = CH_R;  4'd5: char = CH_BLANK;
                    4'd6: char = CH_P;  4'd7: char = CH_I;  4'd8: char = CH_N;
                    default: char = CH_BLANK;
                endcase
            end
            MSG_AMOUNT: begin
                len = 4'd12;
                case (idx)
                    4'd0: char = CH_E;  4'd1: char = CH_N;  4'd2: char = CH_T;
                    4'd3: char = CH_E;  4'd4: char = CH_R;  4'd5: char = CH_BLANK;
                    4'd6: char = CH_A;  4'd7: char = CH_M;  4'd8: char = CH_O;
                    4'd9: char = CH_U;  4'd10: char = CH_N; 4'd11: char = CH_T;
                    default: char = CH_BLANK;
                endcase
            end
            default: begin
                len = 4'd9;
                case (idx)
                    4'd0: char = CH_T;  4'd1: char = CH_A;  4'd2: char = CH_K;
                    4'd3: char = CH_E;  4'd4: char = CH_BLANK; 4'd5: char = CH_C;
                    4'd6: char = CH_A;  4'd7: char = CH_S;  4'd8: char = CH_H;
                    default: char = CH_BLANK;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/scroll_msg_sched.sv
// scroll_msg_sched
// Arbitrates message requests from the ATM FSMs and scrolls one message at a
// time through the 8-character display window, one character per clock,
// followed by 8 blanks, then pulses done.
// Build option: SCROLL_PREEMPT_EN lets a higher-priority (lower index) pending
// request abort the message in flight; otherwise abort is constant 0.
// Ports:
//   sec_clock  in   display-rate clock
//   rst        in   synchronous active-high reset
//   req        in   request bits, bit i requests message i
//   window     out  display window, oldest char in [39:35], newest in [4:0]
//   busy       out  a message is being sequenced
//   active_id  out  ID being sequenced; holds the last ID when idle
//   done       out  one-cycle pulse when a message has fully scrolled off
//   abort      out  one-cycle pulse when a message is preempted
//
// state | meaning
// IDLE  | waiting for a pending request
// SHIFT | shifting message characters into the window
// TAIL  | shifting blanks until the message has left the window
module scroll_msg_sched
    import scroll_pkg::*;
(
    input  logic                        sec_clock,
    input  logic                        rst,
    input  logic [NUM_MSG-1:0]          req,
    output logic [CHAR_W*WIN_CHARS-1:0] window,
    output logic                        busy,
    output logic [ID_W-1:0]             active_id,
    output logic                        done,
    output logic                        abort
);

    localparam int WIN_W = CHAR_W * WIN_CHARS;

    state_t              state;
    logic [NUM_MSG-1:0]  pending;
    logic [IDX_W-1:0]    idx;
    logic [2:0]          tcnt;
    logic [ID_W-1:0]     pri_id;
    logic                pri_valid;
    logic                do_grant;
    logic                do_preempt;
    logic [NUM_MSG-1:0]  gnt_mask;
    logic [CHAR_W-1:0]   rom_char;
    logic [IDX_W-1:0]    rom_len;

    scroll_msg_rom u_rom (
        .id   (active_id),
        .idx  (idx),
        .char (rom_char),
        .len  (rom_len)
    );

    // Lowest pending index wins; scan downward so the last hit is the lowest.
    always_comb begin
        pri_id    = '0;
        pri_valid = 1'b0;
        for (int i = NUM_MSG - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pri_valid = 1'b1;
                pri_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        do_grant = pri_valid && (state == IDLE);
`ifdef SCROLL_PREEMPT_EN
        do_preempt = pri_valid && (state != IDLE) && (pri_id < active_id);
`else
        do_preempt = 1'b0;
`endif
        gnt_mask = (do_grant || do_preempt) ?
                   ({{(NUM_MSG-1){1'b0}}, 1'b1} << pri_id) : '0;
    end

    always_ff @(posedge sec_clock) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            window    <= '0;
            busy      <= 1'b0;
            active_id <= '0;
            done      <= 1'b0;
            abort     <= 1'b0;
            idx       <= '0;
            tcnt      <= '0;
        end else begin
            // A same-edge request for the granted ID survives the clear and replays.
            pending <= (pending & ~gnt_mask) | req;
            done    <= 1'b0;
            abort   <= 1'b0;
            // Preemption takes precedence even on the final tail edge, so an
            // aborted message never also reports done.
            if (do_grant || do_preempt) begin
                active_id <= pri_id;
                window    <= '0;
                idx       <= '0;
                busy      <= 1'b1;
                abort     <= do_preempt;
                state     <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        window <= {window[WIN_W-CHAR_W-1:0], rom_char};
                        idx    <= idx + 4'd1;
                        if (idx == rom_len - 4'd1) begin
                            tcnt  <= '0;
                            state <= TAIL;
                        end
                    end
                    TAIL: begin
                        window <= {window[WIN_W-CHAR_W-1:0], CH_BLANK};
                        tcnt   <= tcnt + 3'd1;
                        if (tcnt == 3'(WIN_CHARS - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scroll_msg_sched.sv
module tb_scroll_msg_sched;

    logic        sec_clock;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] window;
    logic        busy;
    logic [1:0]  active_id;
    logic        done;
    logic        abort;

    int n_chk  = 0;
    int n_fail = 0;

    scroll_msg_sched dut (
        .sec_clock (sec_clock),
        .rst       (rst),
        .req       (req),
        .window    (window),
        .busy      (busy),
        .active_id (active_id),
        .done      (done),
        .abort     (abort)
    );

    initial sec_clock = 1'b0;
    always #5 sec_clock = ~sec_clock;

    // Reference model: a message is a string; after t edges since its grant,
    // the window shows the last 8 entries of (message followed by blanks).
    string msgs [4] = '{"ERROR", "ENTER PIN", "ENTER AMOUNT", "TAKE CASH"};

    logic [3:0] m_pend;
    bit         m_busy, m_done, m_abort;
    int         m_id, m_t, m_g;

    function automatic int lowest(logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic logic [39:0] exp_window(int id, int t);
        logic [39:0] w;
        string s;
        w = '0;
        s = msgs[id];
        for (int j = 0; j < 8; j++) begin
            int k;
            logic [4:0] c;
            k = t - 8 + j;
            c = 5'd0;
            if (k >= 0 && k < s.len() && s[k] != 8'h20) c = 5'(s[k] - 8'd64);
            w[39-5*j -: 5] = c;
        end
        return w;
    endfunction

    function automatic logic [45:0] exp_vec();
        return {exp_window(m_id, m_t), m_busy, m_id[1:0], m_done, m_abort};
    endfunction

    always @(posedge sec_clock) begin
        if (rst) begin
            m_pend = '0; m_busy = 0; m_done = 0; m_abort = 0; m_id = 0; m_t = 0;
        end else begin
            m_done  = 0;
            m_abort = 0;
            m_g     = -1;
            if (!m_busy) begin
                m_g = lowest(m_pend);
            end
`ifdef SCROLL_PREEMPT_EN
            else if (m_pend != 0 && lowest(m_pend) < m_id) begin
                m_g     = lowest(m_pend);
                m_abort = 1;
            end
`endif
            if (m_g >= 0) begin
                m_id = m_g; m_t = 0; m_busy = 1;
                m_pend[m_g] = 1'b0;
            end else if (m_busy) begin
                m_t++;
                if (m_t == msgs[m_id].len() + 8) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            m_pend = m_pend | req;
        end
    end

    logic [45:0] obs;
    assign obs = {window, busy, active_id, done, abort};

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge sec_clock);
        n_chk++;
        if (obs !== 46'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, 46'd0);
        end
        n_chk++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h want %h", obs, exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_amount();
        @(negedge sec_clock) req = 4'b0100;
        @(negedge sec_clock) req = 4'b0000;
        @(negedge sec_clock);
        n_chk++;
        if ({busy, active_id, window} !== {1'b1, 2'd2, 40'd0}) begin
            n_fail++; $display("FAIL amount_grant: got %b/%0d/%h want 1/2/0", busy, active_id, window);
        end
        for (int i = 1; i <= 22; i++) begin
            @(negedge sec_clock);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL amount_model cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (i == 12) begin
                n_chk++;
                if (window !== {5'd18, 5'd0, 5'd1, 5'd13, 5'd15, 5'd21, 5'd14, 5'd20}) begin
                    n_fail++; $display("FAIL amount_window12: got %h want R AMOUNT", window);
                end
            end
            if (i == 20) begin
                n_chk++;
                if ({done, busy, window} !== {1'b1, 1'b0, 40'd0}) begin
                    n_fail++; $display("FAIL amount_done20: got done=%b busy=%b win=%h want 1 0 0", done, busy, window);
                end
            end
            if (i == 21) begin
                n_chk++;
                if (done !== 1'b0) begin
                    n_fail++; $display("FAIL amount_done_pulse: got %b want 0", done);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        @(negedge sec_clock) req = 4'b1010;
        @(negedge sec_clock) req = 4'b0000;
        @(negedge sec_clock);
        n_chk++;
        if ({busy, active_id} !== {1'b1, 2'd1}) begin
            n_fail++; $display("FAIL simul_first: got busy=%b id=%0d want 1 1", busy, active_id);
        end
        for (int i = 1; i <= 37; i++) begin
            @(negedge sec_clock);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL simul_model cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (i == 17) begin
                n_chk++;
                if ({done, busy, active_id} !== {1'b1, 1'b0, 2'd1}) begin
                    n_fail++; $display("FAIL simul_done_pin: got %b%b%0d want done busy=0 id1", done, busy, active_id);
                end
            end
            if (i == 18) begin
                n_chk++;
                if ({done, busy, active_id} !== {1'b0, 1'b1, 2'd3}) begin
                    n_fail++; $display("FAIL simul_second_grant: got %b%b%0d want 0 1 id3", done, busy, active_id);
                end
            end
            if (i == 35) begin
                n_chk++;
                if ({done, active_id} !== {1'b1, 2'd3}) begin
                    n_fail++; $display("FAIL simul_done_cash: got %b %0d want 1 3", done, active_id);
                end
            end
        end
    endtask

    task automatic test_replay();
        int dones;
        dones = 0;
        @(negedge sec_clock) req = 4'b0010;
        @(negedge sec_clock) req = 4'b0000;
        for (int i = 1; i <= 60; i++) begin
            @(negedge sec_clock);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL replay_model cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (done) dones++;
            if (i == 3) req = 4'b0010;
            if (i == 8) req = 4'b0000;
        end
        n_chk++;
        if (dones != 2) begin
            n_fail++; $display("FAIL replay_count: got %0d dones want 2", dones);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL replay_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        int activity;
        activity = 0;
        @(negedge sec_clock) req = 4'b0100;
        @(negedge sec_clock) req = 4'b0000;
        @(negedge sec_clock);
        repeat (3) @(negedge sec_clock);
        rst = 1'b1;
        @(negedge sec_clock);
        n_chk++;
        if (obs !== 46'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %h want 0", obs);
        end
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge sec_clock);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL rstmid_model cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (done || busy) activity++;
        end
        n_chk++;
        if (activity != 0) begin
            n_fail++; $display("FAIL rstmid_no_replay: got %0d active cycles want 0", activity);
        end
    endtask

    task automatic test_preempt();
        int dones, aborts;
        logic [1:0] first_id;
        dones = 0; aborts = 0; first_id = 2'd3;
        @(negedge sec_clock) req = 4'b0100;
        @(negedge sec_clock) req = 4'b0000;
        @(negedge sec_clock);
        for (int i = 1; i <= 45; i++) begin
            @(negedge sec_clock);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL preempt_model cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            if (done) begin
                if (dones == 0) first_id = active_id;
                dones++;
            end
            if (abort) aborts++;
`ifdef SCROLL_PREEMPT_EN
            if (i == 7) begin
                n_chk++;
                if ({abort, active_id, window} !== {1'b1, 2'd0, 40'd0}) begin
                    n_fail++; $display("FAIL preempt_abort: got %b %0d %h want 1 0 0", abort, active_id, window);
                end
            end
            if (i == 8) begin
                n_chk++;
                if (window[4:0] !== 5'd5) begin
                    n_fail++; $display("FAIL preempt_first_char: got %0d want 5", window[4:0]);
                end
            end
`else
            if (i == 20) begin
                n_chk++;
                if ({done, active_id} !== {1'b1, 2'd2}) begin
                    n_fail++; $display("FAIL nopreempt_done: got %b %0d want 1 2", done, active_id);
                end
            end
            if (i == 21) begin
                n_chk++;
                if ({busy, active_id} !== {1'b1, 2'd0}) begin
                    n_fail++; $display("FAIL nopreempt_next: got %b %0d want 1 0", busy, active_id);
                end
            end
`endif
            if (i == 5) req = 4'b0001;
            if (i == 6) req = 4'b0000;
        end
`ifdef SCROLL_PREEMPT_EN
        n_chk++;
        if ({aborts, dones, first_id} !== {32'd1, 32'd1, 2'd0}) begin
            n_fail++; $display("FAIL preempt_counts: got aborts=%0d dones=%0d id=%0d want 1 1 0", aborts, dones, first_id);
        end
`else
        n_chk++;
        if ({aborts, dones, first_id} !== {32'd0, 32'd2, 2'd2}) begin
            n_fail++; $display("FAIL nopreempt_counts: got aborts=%0d dones=%0d id=%0d want 0 2 2", aborts, dones, first_id);
        end
`endif
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL preempt_no_replay: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge sec_clock);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_model cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            req = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0;
        req = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            @(negedge sec_clock);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_drain cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_amount();
        test_simultaneous();
        test_replay();
        test_rst_mid();
        test_preempt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
